// File: rtl/p4_router_ingress_port_adapter.sv
// p4_router_ingress_port_adapter: packs narrow AXIS beats into ingress-bus words behind a 2-entry FIFO
module p4_router_ingress_port_adapter #(
  parameter int IN_BYTES  = 8,
  parameter int OUT_BYTES = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [IN_BYTES*8-1:0]  s_axis_tdata,
  input  logic [IN_BYTES-1:0]    s_axis_tkeep,
  input  logic                   s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [OUT_BYTES*8-1:0] m_axis_tdata,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic [CNT_WIDTH-1:0]   pkt_cnt,
  output logic [CNT_WIDTH-1:0]   proto_err_cnt
);
  localparam int RATIO = OUT_BYTES / IN_BYTES;
  localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;
  localparam int LW    = IN_BYTES * 8;

  if (OUT_BYTES % IN_BYTES != 0) begin : g_bad_ratio
    $error("OUT_BYTES must be a multiple of IN_BYTES");
  end

  logic [OUT_BYTES*8-1:0] asm_data, word_data;
  logic [OUT_BYTES-1:0]   asm_keep, word_keep;
  logic [IW-1:0]          idx;
  logic [OUT_BYTES*8-1:0] fd [2];
  logic [OUT_BYTES-1:0]   fk [2];
  logic [1:0]             fl;
  logic                   rd, wr;
  logic [1:0]             count;
  logic                   in_hs, push, pop;

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign word_data[i*LW +: LW]             = idx == IW'(i) ? s_axis_tdata : asm_data[i*LW +: LW];
    assign word_keep[i*IN_BYTES +: IN_BYTES] = idx == IW'(i) ? s_axis_tkeep : asm_keep[i*IN_BYTES +: IN_BYTES];
  end

  // readiness is a plain registered-count compare; a same-cycle pop does not free a slot
  assign s_axis_tready = !areset && count != 2'd2;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign push          = in_hs && (idx == IW'(RATIO - 1) || s_axis_tlast);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tvalid = count != 2'd0;
  assign m_axis_tdata  = fd[rd];
  assign m_axis_tkeep  = fk[rd];
  assign m_axis_tlast  = fl[rd];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      asm_data      <= '0;
      asm_keep      <= '0;
      idx           <= '0;
      fd[0]         <= '0;
      fd[1]         <= '0;
      fk[0]         <= '0;
      fk[1]         <= '0;
      fl            <= '0;
      rd            <= 1'b0;
      wr            <= 1'b0;
      count         <= '0;
      pkt_cnt       <= '0;
      proto_err_cnt <= '0;
    end else begin
      if (in_hs) begin
        asm_data <= push ? '0 : word_data;
        asm_keep <= push ? '0 : word_keep;
        idx      <= push ? '0 : idx + IW'(1);
      end
      if (push) begin
        fd[wr] <= word_data;
        fk[wr] <= word_keep;
        fl[wr] <= s_axis_tlast;
        wr     <= ~wr;
      end
      if (pop) rd <= ~rd;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (pop && m_axis_tlast) pkt_cnt <= pkt_cnt + 1'b1;
      if (in_hs && !s_axis_tlast && s_axis_tkeep != '1 && proto_err_cnt != '1)
        proto_err_cnt <= proto_err_cnt + 1'b1;
    end
  end
endmodule
